priority_enc8_buf: RTL and testbench

PRIORITY_ENC8_BUF -- requirements
Module: priority_enc8_buf

---
 rtl/priority_enc8_buf.sv | 121 ++++++++++++
 tb/tb_priority_enc8_buf.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_enc8_buf.sv
// 8-bit priority encoder with zero/multi-hot flags, buffered in a 2-entry FIFO.
// Also keeps a saturating count of accepted multi-hot vectors.
module priority_enc8_buf #(
    parameter int unsigned MSB_WINS = 1,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_code,
    output logic             out_zero,
    output logic             out_multi,
    output logic [CNT_W-1:0] err_cnt
);

    // Entry layout: {code[2:0], zero, multi}
    logic [4:0]       ent0_q, ent0_d;
    logic [4:0]       ent1_q, ent1_d;
    logic [1:0]       occ_q, occ_d;
    logic [CNT_W-1:0] err_q, err_d;

    logic [2:0] enc_code;
    logic [3:0] enc_cnt;
    logic       enc_zero;
    logic       enc_multi;
    logic [4:0] new_ent;
    logic       push;
    logic       pop;

    // Scan order makes the last set bit seen the winner.
    always_comb begin
        enc_code = 3'd0;
        enc_cnt  = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (in_vec[i]) begin
                enc_cnt = enc_cnt + 4'd1;
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (MSB_WINS != 0) begin
                if (in_vec[i]) begin
                    enc_code = 3'(i);
                end
            end else begin
                if (in_vec[7-i]) begin
                    enc_code = 3'(7 - i);
                end
            end
        end
    end

    assign enc_zero  = (enc_cnt == 4'd0);
    assign enc_multi = (enc_cnt >= 4'd2);
    assign new_ent   = {enc_code, enc_zero, enc_multi};

    assign in_ready  = rst_n && (occ_q < 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        occ_d  = occ_q;
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        err_d  = err_q;
        unique case (occ_q)
            2'd0: begin
                if (push) begin
                    ent0_d = new_ent;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    ent0_d = new_ent;
                end else if (push) begin
                    ent1_d = new_ent;
                    occ_d  = 2'd2;
                end else if (pop) begin
                    occ_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    ent0_d = ent1_q;
                    occ_d  = 2'd1;
                end
            end
            default: begin
                occ_d = 2'd0;
            end
        endcase
        if (push && enc_multi && (err_q != {CNT_W{1'b1}})) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q  <= 2'd0;
            ent0_q <= 5'd0;
            ent1_q <= 5'd0;
            err_q  <= '0;
        end else begin
            occ_q  <= occ_d;
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            err_q  <= err_d;
        end
    end

    assign out_code  = ent0_q[4:2];
    assign out_zero  = ent0_q[1];
    assign out_multi = ent0_q[0];
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_priority_enc8_buf.sv
// Bench for priority_enc8_buf: three instances (MSB wins, LSB wins, 2-bit counter)
// share stimulus and are checked against a queue-based reference model.
module tb_priority_enc8_buf;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_vec;
    logic       out_ready;

    logic       a_in_ready, a_out_valid, a_out_zero, a_out_multi;
    logic [2:0] a_out_code;
    logic [7:0] a_err_cnt;
    logic       b_in_ready, b_out_valid, b_out_zero, b_out_multi;
    logic [2:0] b_out_code;
    logic [7:0] b_err_cnt;
    logic       c_in_ready, c_out_valid, c_out_zero, c_out_multi;
    logic [2:0] c_out_code;
    logic [1:0] c_err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q[$];
    int         err_w;
    int         err_n;

    always #5 clk = ~clk;

    priority_enc8_buf #(.MSB_WINS(1), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_vec(in_vec), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_code(a_out_code), .out_zero(a_out_zero), .out_multi(a_out_multi),
        .err_cnt(a_err_cnt)
    );
    priority_enc8_buf #(.MSB_WINS(0), .CNT_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_vec(in_vec), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_code(b_out_code), .out_zero(b_out_zero), .out_multi(b_out_multi),
        .err_cnt(b_err_cnt)
    );
    priority_enc8_buf #(.MSB_WINS(1), .CNT_W(2)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_vec(in_vec), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_code(c_out_code), .out_zero(c_out_zero), .out_multi(c_out_multi),
        .err_cnt(c_err_cnt)
    );

    function automatic int msb_idx(logic [7:0] v);
        if (v == 8'd0) return 0;
        return $clog2(int'(v) + 1) - 1;
    endfunction

    function automatic int lsb_idx(logic [7:0] v);
        int x;
        if (v == 8'd0) return 0;
        x = int'(v);
        return $clog2(x & -x);
    endfunction

    function automatic logic is_multi(logic [7:0] v);
        return $countones(v) >= 2;
    endfunction

    // Advance one clock edge and update the reference model for that edge.
    task automatic tick();
        logic       rst, acc, pp;
        logic [7:0] v;
        rst = !rst_n;
        acc = in_valid && !rst && (q.size() < 2);
        pp  = (q.size() != 0) && out_ready;
        v   = in_vec;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            err_w = 0;
            err_n = 0;
        end else begin
            if (pp) q.delete(0);
            if (acc) begin
                q.push_back(v);
                if (is_multi(v)) begin
                    if (err_w != 255) err_w++;
                    if (err_n != 3) err_n++;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_vec = 8'hFF; out_ready = 1'b0;
        #1;
        n_checks++;
        if (a_in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready_low: got %b want 0", a_in_ready);
        end
        tick(); tick();
        n_checks++;
        if ({a_out_valid, a_out_code, a_out_zero, a_out_multi} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b c=%0d z=%b m=%b want all 0",
                     a_out_valid, a_out_code, a_out_zero, a_out_multi);
        end
        n_checks++;
        if (a_err_cnt !== 8'd0 || c_err_cnt !== 2'd0) begin
            n_fail++; $display("FAIL reset_err_cnt: got %0d/%0d want 0", a_err_cnt, c_err_cnt);
        end
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        n_checks++;
        if (a_in_ready !== 1'b1 || c_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %b/%b want 1", a_in_ready, c_in_ready);
        end
    endtask

    task automatic test_walk_one();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_vec = 8'(1 << i);
            tick();
            n_checks++;
            if (a_out_valid !== 1'b1 || a_out_code !== 3'(i) || b_out_code !== 3'(i)
                || a_out_zero !== 1'b0 || a_out_multi !== 1'b0 || a_err_cnt !== 8'd0) begin
                n_fail++;
                $display("FAIL walk_one[%0d]: got v=%b c=%0d/%0d z=%b m=%b e=%0d want 1 %0d 0 0 0",
                         i, a_out_valid, a_out_code, b_out_code, a_out_zero, a_out_multi,
                         a_err_cnt, i);
            end
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (a_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL walk_one_drain: got out_valid=%b want 0", a_out_valid);
        end
    endtask

    task automatic test_priority();
        in_valid = 1'b1; in_vec = 8'hA5; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (a_out_code !== 3'd7 || b_out_code !== 3'd0) begin
            n_fail++;
            $display("FAIL priority_code: got msb=%0d lsb=%0d want 7 0", a_out_code, b_out_code);
        end
        n_checks++;
        if (a_out_multi !== 1'b1 || a_err_cnt !== 8'd1 || c_err_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL priority_multi: got m=%b e=%0d/%0d want 1 1 1",
                     a_out_multi, a_err_cnt, c_err_cnt);
        end
        tick();
    endtask

    task automatic test_zero();
        in_valid = 1'b1; in_vec = 8'h00; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (a_out_valid !== 1'b1 || a_out_code !== 3'd0 || a_out_zero !== 1'b1
            || a_out_multi !== 1'b0 || b_out_code !== 3'd0) begin
            n_fail++;
            $display("FAIL zero_vec: got v=%b c=%0d z=%b m=%b want 1 0 1 0",
                     a_out_valid, a_out_code, a_out_zero, a_out_multi);
        end
        n_checks++;
        if (a_err_cnt !== 8'd1) begin
            n_fail++; $display("FAIL zero_err_cnt: got %0d want 1", a_err_cnt);
        end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1;
        in_vec = 8'h04; tick();
        in_vec = 8'h10; tick();
        n_checks++;
        if (a_in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_full_ready: got %b want 0", a_in_ready);
        end
        in_vec = 8'h20; tick();
        n_checks++;
        if (a_out_code !== 3'd2 || q.size() != 2) begin
            n_fail++; $display("FAIL bp_head_hold: got code=%0d want 2", a_out_code);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_checks++;
        if (a_in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_ready_same_cycle: got %b want 0", a_in_ready);
        end
        tick();
        n_checks++;
        if (a_out_valid !== 1'b1 || a_out_code !== 3'd4 || a_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_second: got v=%b code=%0d rdy=%b want 1 4 1",
                     a_out_valid, a_out_code, a_in_ready);
        end
        tick();
        n_checks++;
        if (a_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_no_dup: got out_valid=%b want 0", a_out_valid);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_seq [5];
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        rst_n = 1'b0; in_valid = 1'b0; tick();
        rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_vec = 8'h03 << i;
            tick();
            n_checks++;
            if (c_err_cnt !== exp_seq[i] || int'(c_err_cnt) != err_n) begin
                n_fail++;
                $display("FAIL saturation[%0d]: got %0d want %0d", i, c_err_cnt, exp_seq[i]);
            end
        end
        in_valid = 1'b0; tick();
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0; tick();
        rst_n = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_vec = 8'h11; tick();
        in_vec = 8'h22; tick();
        out_ready = 1'b0;
        in_vec = 8'h44; tick();
        n_checks++;
        if (c_err_cnt !== 2'd3 || a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_setup: got e=%0d rdy=%b v=%b want 3 0 1",
                     c_err_cnt, a_in_ready, a_out_valid);
        end
        rst_n = 1'b0; in_vec = 8'hC0; tick();
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        n_checks++;
        if (a_out_valid !== 1'b0 || c_err_cnt !== 2'd0 || a_err_cnt !== 8'd0
            || a_out_code !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_reset_clear: got v=%b e=%0d/%0d c=%0d want 0 0 0 0",
                     a_out_valid, a_err_cnt, c_err_cnt, a_out_code);
        end
        n_checks++;
        if (a_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset_ready: got %b want 1", a_in_ready);
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [7:0] hv;
            int         sel;
            rst_n     = ($urandom_range(0, 49) != 0);
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            sel       = int'($urandom_range(0, 3));
            if (sel == 0)      in_vec = 8'h00;
            else if (sel == 1) in_vec = 8'(1 << $urandom_range(0, 7));
            else               in_vec = 8'($urandom);
            #1;
            n_checks++;
            if (a_in_ready !== (rst_n && q.size() < 2) || b_in_ready !== a_in_ready) begin
                n_fail++;
                $display("FAIL rand_in_ready[%0d]: got %b want %b", n, a_in_ready,
                         rst_n && q.size() < 2);
            end
            tick();
            n_checks++;
            if (a_out_valid !== (q.size() != 0) || c_out_valid !== a_out_valid) begin
                n_fail++;
                $display("FAIL rand_out_valid[%0d]: got %b want %b", n, a_out_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                hv = q[0];
                n_checks++;
                if (a_out_code !== 3'(msb_idx(hv)) || b_out_code !== 3'(lsb_idx(hv))
                    || a_out_zero !== (hv == 8'd0) || a_out_multi !== is_multi(hv)
                    || b_out_multi !== is_multi(hv)) begin
                    n_fail++;
                    $display("FAIL rand_head[%0d]: vec=%h got c=%0d/%0d z=%b m=%b want %0d/%0d %b %b",
                             n, hv, a_out_code, b_out_code, a_out_zero, a_out_multi,
                             msb_idx(hv), lsb_idx(hv), hv == 8'd0, is_multi(hv));
                end
            end
            n_checks++;
            if (int'(a_err_cnt) != err_w || int'(b_err_cnt) != err_w
                || int'(c_err_cnt) != err_n) begin
                n_fail++;
                $display("FAIL rand_err_cnt[%0d]: got %0d/%0d/%0d want %0d/%0d", n, a_err_cnt,
                         b_err_cnt, c_err_cnt, err_w, err_n);
            end
        end
    endtask

    initial begin
        err_w = 0;
        err_n = 0;
        test_reset();
        test_walk_one();
        test_priority();
        test_zero();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
